// File: rtl/multi_digit_counter_pkg.sv
// multi_digit_counter_pkg: digit width and active-low seven-segment patterns (abcdefg, a in bit 6)
package multi_digit_counter_pkg;
    localparam int DIG_W = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
endpackage

// File: rtl/multi_digit_counter_seg7_decode.sv
// seg7_decode: one digit to active-low segments, forced dark when blank is set
module seg7_decode
    import multi_digit_counter_pkg::*;
(
    input  logic [DIG_W-1:0] digit,
    input  logic             blank,
    output logic [6:0]       seg
);
    assign seg = blank ? SEG_BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/multi_digit_counter.sv
// multi_digit_counter: NDIG-digit BCD/hex up/down counter with load, terminal-count pulse and 7-seg outputs
module multi_digit_counter
    import multi_digit_counter_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int BCD      = 1,
    parameter int SAT      = 0,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [DIG_W*NDIG-1:0] load_val,
    output logic [DIG_W*NDIG-1:0] count,
    output logic                  tc,
    output logic [7*NDIG-1:0]     hex
);
    localparam int W = DIG_W * NDIG;
    localparam logic [DIG_W-1:0] DMAX = (BCD != 0) ? 4'd9 : 4'd15;
    logic [W-1:0] count_q, count_d, step_val, load_sat;
    logic         tc_q, tc_d;
    logic         cy [NDIG+1];
    logic         zr [NDIG+1];
    assign cy[0]    = 1'b1;
    assign zr[NDIG] = 1'b1;
    // cy[i]: every digit below i sits at its limit, so digit i takes the step
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic [DIG_W-1:0] d, ld;
        logic             at_lim;
        assign d      = count_q[i*DIG_W +: DIG_W];
        assign ld     = load_val[i*DIG_W +: DIG_W];
        assign at_lim = up ? (d >= DMAX) : (d == 4'd0);
        assign cy[i+1] = cy[i] & at_lim;
        assign step_val[i*DIG_W +: DIG_W] = !cy[i] ? d : at_lim ? (up ? 4'd0 : DMAX) : up ? d + 4'd1 : d - 4'd1;
        assign load_sat[i*DIG_W +: DIG_W] = (BCD != 0 && ld > 4'd9) ? 4'd9 : ld;
        assign zr[i] = zr[i+1] & (d == 4'd0);
        seg7_decode u_seg (
            .digit(d),
            .blank(BLANK_LZ != 0 && i != 0 && zr[i]),
            .seg  (hex[i*7 +: 7])
        );
    end
    // cy[NDIG] means the whole count is at the limit for the current direction
    always_comb begin
        count_d = reset ? '0 : load ? load_sat : (enable && !(SAT != 0 && cy[NDIG])) ? step_val : count_q;
        tc_d    = !reset && !load && enable && cy[NDIG];
    end
    always_ff @(posedge clk) begin
        count_q <= count_d;
        tc_q    <= tc_d;
    end
    assign count = count_q;
    assign tc    = tc_q;
endmodule

// File: tb/tb_multi_digit_counter.sv
// tb_multi_digit_counter: four parameter variants on shared random stimulus against an arithmetic model
module tb_multi_digit_counter;
    logic        clk = 1'b0;
    logic        reset, enable, up, load;
    logic [15:0] load_val;
    logic [15:0] cnt [4];
    logic        tcv [4];
    logic [27:0] hx  [4];
    int checks = 0, failures = 0;
    int     base [4] = '{10, 16, 16, 10};
    bit     sat  [4] = '{0, 1, 0, 1};
    bit     blz  [4] = '{0, 0, 1, 1};
    longint mv   [4] = '{0, 0, 0, 0};
    bit     mtc  [4] = '{0, 0, 0, 0};
    bit [6:0] pat [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    always #5 clk = ~clk;
    multi_digit_counter #(.NDIG(4), .BCD(1), .SAT(0), .BLANK_LZ(0)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .count(cnt[0]), .tc(tcv[0]), .hex(hx[0]));
    multi_digit_counter #(.NDIG(4), .BCD(0), .SAT(1), .BLANK_LZ(0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .count(cnt[1]), .tc(tcv[1]), .hex(hx[1]));
    multi_digit_counter #(.NDIG(4), .BCD(0), .SAT(0), .BLANK_LZ(1)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .count(cnt[2]), .tc(tcv[2]), .hex(hx[2]));
    multi_digit_counter #(.NDIG(4), .BCD(1), .SAT(1), .BLANK_LZ(1)) u_d (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .count(cnt[3]), .tc(tcv[3]), .hex(hx[3]));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic longint pw(input int b, input int e);
        longint r = 1;
        for (int j = 0; j < e; j++) r *= b;
        return r;
    endfunction
    function automatic logic [15:0] digits(input longint v, input int b);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / pw(b, i)) % b);
        return r;
    endfunction
    function automatic logic [27:0] segs(input longint v, input int b, input bit bl);
        logic [27:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[i*7 +: 7] = (bl && i > 0 && v < pw(b, i)) ? 7'h7f : pat[(v / pw(b, i)) % b];
        return r;
    endfunction
    task automatic model(input int k);
        longint mx = pw(base[k], 4) - 1;
        bit lim = up ? (mv[k] == mx) : (mv[k] == 0);
        if (reset) begin
            mv[k] = 0; mtc[k] = 0;
        end else if (load) begin
            mv[k] = 0;
            for (int i = 0; i < 4; i++)
                mv[k] += longint'((load_val[i*4 +: 4] > 9 && base[k] == 10) ? 9 : load_val[i*4 +: 4]) * pw(base[k], i);
            mtc[k] = 0;
        end else if (enable) begin
            mtc[k] = lim;
            if (lim) mv[k] = sat[k] ? mv[k] : (up ? 0 : mx);
            else mv[k] = up ? mv[k] + 1 : mv[k] - 1;
        end else mtc[k] = 0;
    endtask
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 4; k++) model(k);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cnt%0d", k), 32'(cnt[k]), 32'(digits(mv[k], base[k])));
            check($sformatf("tc%0d", k), 32'(tcv[k]), 32'(mtc[k]));
            check($sformatf("hex%0d", k), 32'(hx[k]), 32'(segs(mv[k], base[k], blz[k])));
        end
    endtask
    task automatic drive(input bit r, input bit l, input bit e, input bit u, input logic [15:0] lv);
        reset = r; load = l; enable = e; up = u; load_val = lv;
        tick();
    endtask
    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; load_val = '0;
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("rst_hex_a", 32'(hx[0]), 32'h0204081);
        check("rst_hex_d", 32'(hx[3]), 32'hFFFFF81);
        drive(0, 1, 0, 1, 16'h9999);
        drive(0, 0, 1, 1, 0);
        check("wrap_cnt", 32'(cnt[0]), 32'h0);
        check("wrap_tc", 32'(tcv[0]), 32'h1);
        drive(0, 0, 0, 1, 0);
        check("wrap_tc_once", 32'(tcv[0]), 32'h0);
        drive(0, 1, 0, 1, 16'h12F9);
        check("ld_clamp", 32'(cnt[0]), 32'h1299);
        check("ld_hex1", 32'(hx[0][13:7]), 32'b0000100);
        check("ld_no_tc", 32'(tcv[0]), 32'h0);
        drive(0, 1, 0, 0, 16'h0000);
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 1, 0, 0);
            check($sformatf("sat_cnt%0d", n), 32'(cnt[1]), 32'h0);
            check($sformatf("sat_tc%0d", n), 32'(tcv[1]), 32'h1);
        end
        drive(0, 1, 0, 1, 16'h0199);
        drive(0, 0, 1, 1, 0);
        check("up_0200", 32'(cnt[0]), 32'h0200);
        drive(0, 0, 1, 0, 0);
        check("dn_0199", 32'(cnt[0]), 32'h0199);
        drive(0, 0, 1, 0, 0);
        check("dn_0198", 32'(cnt[0]), 32'h0198);
        drive(0, 1, 0, 1, 16'h0042);
        check("blank_hex", 32'(hx[2]), {4'h0, 7'h7f, 7'h7f, 7'b1001100, 7'b0010010});
        drive(0, 1, 0, 1, 16'h0555);
        drive(1, 1, 1, 1, 16'h1234);
        check("rst_pri_cnt", 32'(cnt[0]), 32'h0);
        check("rst_pri_tc", 32'(tcv[0]), 32'h0);
        for (int n = 0; n < 600; n++) begin
            int r = int'($urandom_range(0, 5));
            logic [15:0] lv = r == 0 ? 16'h9999 : r == 1 ? 16'hFFFF : r == 2 ? 16'h0000 : 16'($urandom);
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, lv);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
